// File: rtl/digest_variant_search.sv
// Steps one squeezed 128-bit word through four byte-order conversions.
// Each candidate is compared against an expected digest, and the matching variant(s) are reported.
module digest_variant_search #(
  parameter bit STOP_ON_FIRST = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [127:0]     exp_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             match,
  output logic [1:0]       variant,
  output logic [3:0]       match_mask,
  output logic [127:0]     cand_data,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t       state, state_next;
  logic [127:0] d_reg, e_reg;
  logic [1:0]   idx;
  logic         eq;
  logic         finish;
  logic [3:0]   mask_next;
  logic [1:0]   low_idx;

  function automatic logic [63:0] bswap64(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = x[8*(7-i) +: 8];
    return r;
  endfunction

  function automatic logic [127:0] conv(input logic [1:0] v, input logic [127:0] x);
    logic [127:0] r;
    case (v)
      2'd0:    r = x;
      2'd1:    r = {bswap64(x[127:64]), bswap64(x[63:0])};
      2'd2:    r = {bswap64(x[63:0]), bswap64(x[127:64])};
      default: r = {x[63:0], x[127:64]};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The sweep ends on the first hit when STOP_ON_FIRST is set, or else after variant 3.
  always_comb begin
    state_next = state;
    finish     = 1'b0;
    eq         = (conv(idx, d_reg) == e_reg);
    mask_next  = match_mask | ({3'b000, eq} << idx);
    case (state)
      IDLE:  if (in_valid) state_next = CHECK;
      CHECK: begin
        if ((eq && STOP_ON_FIRST) || idx == 2'd3) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    low_idx = 2'd0;
    if      (mask_next[0]) low_idx = 2'd0;
    else if (mask_next[1]) low_idx = 2'd1;
    else if (mask_next[2]) low_idx = 2'd2;
    else if (mask_next[3]) low_idx = 2'd3;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_reg      <= '0;
      e_reg      <= '0;
      idx        <= 2'd0;
      match_mask <= 4'd0;
      match      <= 1'b0;
      variant    <= 2'd0;
      cand_data  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            d_reg      <= in_data;
            e_reg      <= exp_data;
            match_mask <= 4'd0;
            idx        <= 2'd0;
          end
        end
        CHECK: begin
          match_mask <= mask_next;
          if (finish) begin
            match     <= |mask_next;
            variant   <= low_idx;
            cand_data <= conv(low_idx, d_reg);
            // Saturate rather than wrap so a long run of misses stays visible.
            if (!(|mask_next) && miss_count != {CNT_W{1'b1}})
              miss_count <= miss_count + CNT_W'(1);
          end else begin
            idx <= idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digest_variant_search.sv
// Directed bench for digest_variant_search: instance A stops on first match (16-bit counter),
// instance B sweeps all variants with a 3-bit counter so saturation is reachable quickly.
module tb_digest_variant_search;

  localparam logic [127:0] W  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] V1 = 128'h7766554433221100FFEEDDCCBBAA9988;
  localparam logic [127:0] V2 = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [127:0] V3 = 128'h8899AABBCCDDEEFF0011223344556677;
  localparam logic [127:0] AA = {16{8'hAA}};

  logic         clk, rst, out_ready;
  logic [127:0] in_data, exp_data;
  logic         in_valid_a, in_ready_a, out_valid_a, match_a;
  logic [1:0]   variant_a;
  logic [3:0]   match_mask_a;
  logic [127:0] cand_data_a;
  logic [15:0]  miss_count_a;
  logic         in_valid_b, in_ready_b, out_valid_b, match_b;
  logic [1:0]   variant_b;
  logic [3:0]   match_mask_b;
  logic [127:0] cand_data_b;
  logic [2:0]   miss_count_b;

  int n_checks = 0;
  int n_fail   = 0;

  digest_variant_search #(.STOP_ON_FIRST(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data), .exp_data(exp_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .match(match_a), .variant(variant_a), .match_mask(match_mask_a),
    .cand_data(cand_data_a), .miss_count(miss_count_a)
  );

  digest_variant_search #(.STOP_ON_FIRST(1'b0), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data), .exp_data(exp_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .match(match_b), .variant(variant_b), .match_mask(match_mask_b),
    .cand_data(cand_data_b), .miss_count(miss_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lat = number of edges after the accepting edge until out_valid is seen (20 = timed out)
  task automatic search_a(input logic [127:0] w, input logic [127:0] x, output int lat);
    @(negedge clk);
    in_data = w; exp_data = x; in_valid_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    lat = 0;
    while (out_valid_a !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic search_b(input logic [127:0] w, input logic [127:0] x, output int lat);
    @(negedge clk);
    in_data = w; exp_data = x; in_valid_b = 1'b1;
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    lat = 0;
    while (out_valid_b !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic retire();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
    in_data = '0; exp_data = '0;
    #12 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_ready_a !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready_a); end
    n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid_a); end
    n_checks++; if ({match_a, variant_a, match_mask_a} !== 7'd0) begin n_fail++; $display("[TB] FAIL reset_result got %b want 0", {match_a, variant_a, match_mask_a}); end
    n_checks++; if (cand_data_a !== 128'd0) begin n_fail++; $display("[TB] FAIL reset_cand got %h want 0", cand_data_a); end
    n_checks++; if (miss_count_a !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_miss got %0d want 0", miss_count_a); end
    n_checks++; if (in_ready_b !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready_b got %b want 1", in_ready_b); end
  endtask

  task automatic test_stop_first();
    logic [127:0] exps [4];
    int lat;
    exps[0] = W; exps[1] = V1; exps[2] = V2; exps[3] = V3;
    for (int k = 0; k < 4; k++) begin
      search_a(W, exps[k], lat);
      n_checks++; if (lat != k + 1) begin n_fail++; $display("[TB] FAIL stop_latency v%0d got %0d want %0d", k, lat, k + 1); end
      n_checks++; if (match_a !== 1'b1 || variant_a !== 2'(k)) begin n_fail++; $display("[TB] FAIL stop_variant v%0d got match=%b var=%0d", k, match_a, variant_a); end
      n_checks++; if (match_mask_a !== 4'(1 << k)) begin n_fail++; $display("[TB] FAIL stop_mask v%0d got %b want %b", k, match_mask_a, 4'(1 << k)); end
      n_checks++; if (cand_data_a !== exps[k]) begin n_fail++; $display("[TB] FAIL stop_cand v%0d got %h want %h", k, cand_data_a, exps[k]); end
      n_checks++; if (in_ready_a !== 1'b0 || miss_count_a !== 16'd0) begin n_fail++; $display("[TB] FAIL stop_busy v%0d got in_ready=%b miss=%0d", k, in_ready_a, miss_count_a); end
      retire();
      n_checks++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL stop_retire v%0d got in_ready=%b out_valid=%b", k, in_ready_a, out_valid_a); end
    end
  endtask

  task automatic test_miss();
    int lat;
    search_a(W, 128'd0, lat);
    n_checks++; if (lat != 4) begin n_fail++; $display("[TB] FAIL miss_latency got %0d want 4", lat); end
    n_checks++; if ({match_a, variant_a, match_mask_a} !== 7'd0) begin n_fail++; $display("[TB] FAIL miss_result got %b want 0", {match_a, variant_a, match_mask_a}); end
    n_checks++; if (cand_data_a !== W) begin n_fail++; $display("[TB] FAIL miss_cand got %h want %h", cand_data_a, W); end
    n_checks++; if (miss_count_a !== 16'd1) begin n_fail++; $display("[TB] FAIL miss_count got %0d want 1", miss_count_a); end
    retire();
  endtask

  task automatic test_hold();
    int lat;
    int bad;
    search_a(W, V2, lat);
    @(negedge clk);
    in_valid_a = 1'b1; in_data = ~W; exp_data = ~W;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid_a !== 1'b1 || in_ready_a !== 1'b0 || match_a !== 1'b1 || variant_a !== 2'd2 ||
          match_mask_a !== 4'b0100 || cand_data_a !== V2) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("[TB] FAIL hold_stable got %0d unstable cycles want 0", bad); end
    @(negedge clk);
    in_valid_a = 1'b0;
    retire();
    n_checks++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_release got in_ready=%b out_valid=%b", in_ready_a, out_valid_a); end
    n_checks++; if (variant_a !== 2'd2 || cand_data_a !== V2) begin n_fail++; $display("[TB] FAIL hold_stale got var=%0d cand=%h", variant_a, cand_data_a); end
    n_checks++; if (miss_count_a !== 16'd1) begin n_fail++; $display("[TB] FAIL hold_miss got %0d want 1", miss_count_a); end
  endtask

  task automatic test_sweep();
    int lat;
    search_b(AA, AA, lat);
    n_checks++; if (lat != 4) begin n_fail++; $display("[TB] FAIL sweep_latency got %0d want 4", lat); end
    n_checks++; if (match_mask_b !== 4'b1111 || variant_b !== 2'd0 || match_b !== 1'b1) begin n_fail++; $display("[TB] FAIL sweep_all got mask=%b var=%0d", match_mask_b, variant_b); end
    n_checks++; if (cand_data_b !== AA) begin n_fail++; $display("[TB] FAIL sweep_all_cand got %h want %h", cand_data_b, AA); end
    retire();
    search_b(W, V2, lat);
    n_checks++; if (lat != 4) begin n_fail++; $display("[TB] FAIL sweep_v2_latency got %0d want 4", lat); end
    n_checks++; if (match_mask_b !== 4'b0100 || variant_b !== 2'd2 || cand_data_b !== V2) begin n_fail++; $display("[TB] FAIL sweep_v2 got mask=%b var=%0d cand=%h", match_mask_b, variant_b, cand_data_b); end
    retire();
    search_b(W, 128'd0, lat);
    n_checks++; if (match_b !== 1'b0 || match_mask_b !== 4'd0 || cand_data_b !== W) begin n_fail++; $display("[TB] FAIL sweep_miss got match=%b mask=%b cand=%h", match_b, match_mask_b, cand_data_b); end
    n_checks++; if (miss_count_b !== 3'd1) begin n_fail++; $display("[TB] FAIL sweep_miss_count got %0d want 1", miss_count_b); end
    retire();
  endtask

  task automatic test_abort_reset();
    int bad;
    @(negedge clk);
    in_data = W; exp_data = 128'd0; in_valid_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_out_valid got %b want 0", out_valid_a); end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_ready_a !== 1'b1 || miss_count_a !== 16'd0) begin n_fail++; $display("[TB] FAIL abort_state got in_ready=%b miss=%0d", in_ready_a, miss_count_a); end
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid_a !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("[TB] FAIL abort_no_result got %0d valid cycles want 0", bad); end
  endtask

  task automatic test_saturation();
    int lat;
    int want;
    for (int i = 1; i <= 9; i++) begin
      search_b(W, 128'd0, lat);
      want = (i > 7) ? 7 : i;
      n_checks++; if (miss_count_b !== 3'(want)) begin n_fail++; $display("[TB] FAIL sat_count iter%0d got %0d want %0d", i, miss_count_b, want); end
      retire();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_stop_first();
    test_miss();
    test_hold();
    test_sweep();
    test_abort_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
